mem_access_stage: RTL and testbench

- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and MEM_WB_reg.
- Drives a word-wide data-memory request/ready port and performs byte/half/word lane steering, load sign/zero extension and misalignment checks.
- Stalls the pipeline while a memory access is outstanding; non-memory instructions pass through combinationally.

---
 rtl/mips_mem_pkg.sv | 69 ++++++
 rtl/load_align.sv | 39 +++
 rtl/mem_access_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared encodings, FSM state type and lane-steering helpers for
//               the MEM-stage data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  // mem_size encodings; 2'b11 is treated as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_WAIT_DEFAULT = 255;
  localparam int WAIT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // A half must sit on an even address, a word on a multiple of four
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Byte enables for a store of the given size at the given lane
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate sub-word store data across every lane so the memory can pick
  // whichever lane the byte enables select
  function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                              input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load lane select with sign/zero extension.
//               Kept standalone so a future data cache can share it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then extend it to a full word
  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (mem_size)
      SZ_BYTE: result = {{24{w_byte[7]  & ~mem_unsigned}}, w_byte};
      SZ_HALF: result = {{16{w_half[15] & ~mem_unsigned}}, w_half};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM-stage data-memory access unit. Issues word-wide
//               request/ready transactions with byte-lane steering, extends
//               load data, drops misaligned accesses and stalls the pipeline
//               while an access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_result_out,
  output logic [31:0] memoryread,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  // Last BUSY cycle index before the access is abandoned
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_data;
  logic              r_err;

  // Request fields captured at issue so BUSY drives a stable request
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_is_load;
  logic [1:0]        r_addr_lo;
  logic [1:0]        r_size;
  logic              r_unsigned;

  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_issue;
  logic              w_timeout;
  logic [31:0]       w_word_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  // A memory op is only recognised while out of reset
  assign w_mem_op     = reset & valid_in & (MemRead | MemWrite);
  assign w_misaligned = is_misaligned(mem_size, alu_result[1:0]);
  assign w_issue      = (r_state == IDLE) & w_mem_op & ~w_misaligned;
  assign w_timeout    = (r_state == BUSY) & ~dmem_ready & (r_wait == c_WAIT_LAST);
  assign w_word_addr  = {alu_result[31:2], 2'b00};
  assign w_be         = MemWrite ? store_be(mem_size, alu_result[1:0]) : 4'b0000;
  assign w_wdata      = MemWrite ? store_wdata(mem_size, write_data) : 32'h0;

  load_align u_load_align (
    .rdata        (dmem_rdata),
    .addr_lo      (r_addr_lo),
    .mem_size     (r_size),
    .mem_unsigned (r_unsigned),
    .result       (w_load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: IDLE issues, BUSY waits for ready or timeout, DONE retires
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next = BUSY;
      BUSY:    if (dmem_ready || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, wait counter, read-data latch and bus-error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait     <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_is_load  <= 1'b0;
      r_addr_lo  <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait <= '0;
          r_err  <= 1'b0;
          if (w_issue) begin
            r_we       <= MemWrite;
            r_addr     <= w_word_addr;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_is_load  <= MemRead & ~MemWrite;
            r_addr_lo  <= alu_result[1:0];
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            // Stores return no write-back data
            r_data <= r_is_load ? w_load_data : 32'h0;
          end else if (w_timeout) begin
            r_data <= 32'h0;
            r_err  <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        DONE: begin
          r_wait <= '0;
          r_err  <= 1'b0;
        end
        default: begin
          r_wait <= '0;
          r_err  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: pass-through by default, bubbles while stalled or dropped
  always_comb begin
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = w_word_addr;
    dmem_be        = 4'b0000;
    dmem_wdata     = 32'h0;
    alu_result_out = alu_result;
    rd_out         = rd;
    MemToReg_out   = MemToReg;
    RegWrite_out   = RegWrite;
    memoryread     = 32'h0;
    stall          = 1'b0;
    misalign_exc   = 1'b0;
    bus_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op && w_misaligned) begin
          misalign_exc = 1'b1;
          RegWrite_out = 1'b0;
        end else if (w_issue) begin
          dmem_req     = 1'b1;
          dmem_we      = MemWrite;
          dmem_be      = w_be;
          dmem_wdata   = w_wdata;
          stall        = 1'b1;
          RegWrite_out = 1'b0;
        end
      end
      BUSY: begin
        dmem_req     = 1'b1;
        dmem_we      = r_we;
        dmem_addr    = r_addr;
        dmem_be      = r_be;
        dmem_wdata   = r_wdata;
        stall        = 1'b1;
        RegWrite_out = 1'b0;
      end
      DONE: begin
        memoryread   = r_data;
        RegWrite_out = RegWrite & ~r_err;
        bus_err      = r_err;
      end
      default: begin
        RegWrite_out = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage with a small
//               arithmetic reference model of lane steering and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TB_MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        RegWrite;
  logic        MemToReg;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_result_out;
  logic [31:0] memoryread;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
  logic        MemToReg_out;
  logic        stall;
  logic        misalign_exc;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .alu_result     (alu_result),
    .write_data     (write_data),
    .rd             (rd),
    .RegWrite       (RegWrite),
    .MemToReg       (MemToReg),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .alu_result_out (alu_result_out),
    .memoryread     (memoryread),
    .rd_out         (rd_out),
    .RegWrite_out   (RegWrite_out),
    .MemToReg_out   (MemToReg_out),
    .stall          (stall),
    .misalign_exc   (misalign_exc),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'((a / 2) % 2);
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] one = 4'b0001;
    logic [3:0] two = 4'b0011;
    if (sz == 2'd0)      return one << (a % 4);
    else if (sz == 2'd1) return two << (2 * ((a / 2) % 2));
    else                 return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0)      return (wd & 32'hFF)   * 32'h0101_0101;
    else if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    else                 return wd;
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd1)      return (a % 2) != 0;
    else if (sz >= 2'd2) return (a % 4) != 0;
    else                 return 1'b0;
  endfunction

  task automatic idle_inputs;
    valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // One load/store; ready arrives in BUSY cycle k (1..TB_MAX_WAIT)
  task automatic run_op(input string nm, input logic [31:0] addr, input logic [31:0] wd,
                        input logic is_wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] rdata, input int k);
    logic [31:0] exp_addr, exp_wdata, exp_mr;
    logic [3:0]  exp_be;
    logic [4:0]  rdv;
    logic        rw;
    rdv       = 5'($urandom_range(1, 31));
    rw        = ~is_wr;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = is_wr ? ref_be(addr, sz) : 4'b0000;
    exp_wdata = is_wr ? ref_wdata(wd, sz) : 32'h0;
    exp_mr    = is_wr ? 32'h0 : ref_load(rdata, addr, sz, uns);

    @(posedge clk); #1;
    valid_in = 1'b1; alu_result = addr; write_data = wd; rd = rdv;
    RegWrite = rw; MemToReg = ~is_wr; MemRead = ~is_wr; MemWrite = is_wr;
    mem_size = sz; mem_unsigned = uns;
    dmem_ready = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    dmem_rdata = $urandom;
    @(negedge clk);
    if (ref_misaligned(addr, sz)) begin
      checks++;
      if ({dmem_req, stall, misalign_exc, RegWrite_out, bus_err} !== 5'b00100) begin
        errors++;
        $display("FAIL %s misalign: req/stall/exc/rw/berr=%b want 00100", nm,
                 {dmem_req, stall, misalign_exc, RegWrite_out, bus_err});
      end
    end else begin
      checks++;
      if ({dmem_req, dmem_we, stall, RegWrite_out, misalign_exc} !== {1'b1, is_wr, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s issue ctl: req/we/stall/rw/exc=%b want %b", nm,
                 {dmem_req, dmem_we, stall, RegWrite_out, misalign_exc}, {1'b1, is_wr, 3'b100});
      end
      checks++;
      if ({dmem_addr, dmem_be, dmem_wdata} !== {exp_addr, exp_be, exp_wdata}) begin
        errors++;
        $display("FAIL %s issue req: addr=%h be=%b wdata=%h want addr=%h be=%b wdata=%h", nm,
                 dmem_addr, dmem_be, dmem_wdata, exp_addr, exp_be, exp_wdata);
      end
      for (int b = 1; b <= k; b++) begin
        @(posedge clk); #1;
        dmem_ready = (b == k);
        dmem_rdata = (b == k) ? rdata : $urandom;
        @(negedge clk);
        checks++;
        if ({dmem_req, stall, RegWrite_out, bus_err} !== 4'b1100 ||
            {dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {exp_addr, exp_be, exp_wdata, is_wr}) begin
          errors++;
          $display("FAIL %s busy%0d: req/stall/rw/berr=%b addr=%h be=%b wdata=%h want 1100 %h %b %h",
                   nm, b, {dmem_req, stall, RegWrite_out, bus_err}, dmem_addr, dmem_be, dmem_wdata,
                   exp_addr, exp_be, exp_wdata);
        end
      end
      @(posedge clk); #1;
      dmem_ready = 1'($urandom_range(0, 1));   // must be ignored in DONE
      dmem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({dmem_req, stall, bus_err, misalign_exc} !== 4'b0000) begin
        errors++;
        $display("FAIL %s done ctl: req/stall/berr/exc=%b want 0000", nm,
                 {dmem_req, stall, bus_err, misalign_exc});
      end
      checks++;
      if (memoryread !== exp_mr) begin
        errors++;
        $display("FAIL %s memoryread: got %h want %h", nm, memoryread, exp_mr);
      end
      checks++;
      if ({RegWrite_out, rd_out, MemToReg_out, alu_result_out} !== {rw, rdv, ~is_wr, addr}) begin
        errors++;
        $display("FAIL %s done wb: rw=%b rd=%0d m2r=%b alu=%h want %b %0d %b %h", nm,
                 RegWrite_out, rd_out, MemToReg_out, alu_result_out, rw, rdv, ~is_wr, addr);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; idle_inputs();
    alu_result = 32'h0; write_data = 32'h0; rd = 5'd0; mem_size = 2'd0; mem_unsigned = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, misalign_exc, bus_err, memoryread} !== 36'h0) begin
      errors++;
      $display("FAIL reset: req/stall/exc/berr=%b memoryread=%h want 0", 
               {dmem_req, stall, misalign_exc, bus_err}, memoryread);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_passthrough;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid_in = 1'($urandom_range(0, 1));
      MemRead = valid_in ? 1'b0 : 1'($urandom_range(0, 1));
      MemWrite = 1'b0;
      alu_result = $urandom; write_data = $urandom; rd = 5'($urandom);
      RegWrite = 1'($urandom_range(0, 1)); MemToReg = 1'($urandom_range(0, 1));
      mem_size = 2'($urandom); dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({alu_result_out, rd_out, RegWrite_out, MemToReg_out} !== {alu_result, rd, RegWrite, MemToReg} ||
          {dmem_req, stall, misalign_exc, bus_err} !== 4'b0000 || memoryread !== 32'h0) begin
        errors++;
        $display("FAIL passthrough%0d: alu=%h rd=%0d rw=%b m2r=%b ctl=%b mr=%h want %h %0d %b %b 0000 0",
                 i, alu_result_out, rd_out, RegWrite_out, MemToReg_out,
                 {dmem_req, stall, misalign_exc, bus_err}, memoryread, alu_result, rd, RegWrite, MemToReg);
      end
    end
  endtask

  task automatic test_loads;
    run_op("lb",  32'h0000_1003, 32'h0, 1'b0, 2'd0, 1'b0, 32'h80FF_1234, 2);
    run_op("lhu", 32'h0000_2002, 32'h0, 1'b0, 2'd1, 1'b1, 32'h8001_7FFF, 1);
    run_op("lh",  32'h0000_2000, 32'h0, 1'b0, 2'd1, 1'b0, 32'h8001_7FFF, 3);
    run_op("lbu", 32'h0000_2001, 32'h0, 1'b0, 2'd0, 1'b1, 32'h0000_F000, 1);
  endtask

  task automatic test_stores;
    run_op("sb", 32'h0000_3001, 32'h1234_56AB, 1'b1, 2'd0, 1'b0, 32'h0, 1);
    run_op("sh", 32'h0000_3006, 32'hCAFE_BEEF, 1'b1, 2'd1, 1'b0, 32'h0, 2);
    run_op("sw", 32'h0000_3004, 32'h89AB_CDEF, 1'b1, 2'd2, 1'b0, 32'h0, 4);
  endtask

  task automatic test_misalign;
    run_op("lw_mis", 32'h0000_4002, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1);
    run_op("sh_mis", 32'h0000_4003, 32'h5555_AAAA, 1'b1, 2'd1, 1'b0, 32'h0, 1);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_lw", 32'h0000_7008, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1357_9BDF, 1);
    run_op("b2b_sw", 32'h0000_700C, 32'h2468_ACE0, 1'b1, 2'd3, 1'b0, 32'h0, 1);
  endtask

  task automatic test_timeout;
    @(posedge clk); #1;
    valid_in = 1'b1; alu_result = 32'h0000_5000; rd = 5'd9; RegWrite = 1'b1; MemToReg = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL timeout issue: req/stall=%b want 11", {dmem_req, stall});
    end
    for (int b = 1; b <= TB_MAX_WAIT; b++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({dmem_req, stall, bus_err} !== 3'b110) begin
        errors++;
        $display("FAIL timeout busy%0d: req/stall/berr=%b want 110", b, {dmem_req, stall, bus_err});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, bus_err, RegWrite_out} !== 4'b0010 || memoryread !== 32'h0) begin
      errors++;
      $display("FAIL timeout done: req/stall/berr/rw=%b mr=%h want 0010 0",
               {dmem_req, stall, bus_err, RegWrite_out}, memoryread);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL timeout idle: req/stall/berr=%b want 000", {dmem_req, stall, bus_err});
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    valid_in = 1'b1; alu_result = 32'h0000_6004; rd = 5'd3; RegWrite = 1'b1; MemToReg = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; mem_size = 2'd2; dmem_ready = 1'b0;
    @(posedge clk); #1;                      // now in BUSY
    reset = 1'b0; idle_inputs();
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid busy: req=%b want 1", dmem_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid after: req/stall=%b want 00", {dmem_req, stall});
    end
    @(posedge clk); #1;
    reset = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, bus_err} !== 3'b000 || memoryread !== 32'h0) begin
      errors++;
      $display("FAIL rstmid late ready: req/stall/berr=%b mr=%h want 000 0",
               {dmem_req, stall, bus_err}, memoryread);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rdat;
    logic [1:0]  sz;
    logic        wr, uns;
    for (int i = 0; i < 40; i++) begin
      a    = {16'h0, 16'($urandom)};
      wd   = $urandom;
      rdat = $urandom;
      sz   = 2'($urandom);
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      run_op("rand", a, wd, wr, sz, uns, rdat, int'($urandom_range(1, TB_MAX_WAIT)));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    @(posedge clk); #1;
    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
